// File: rtl/ballot_collector.sv
// -----------------------------------------------------------------------------
// ballot_collector
//
// Sequential front end for the combinational vote evaluator. It takes one
// ballot per valid/ready handshake and rejects malformed or duplicate ballots.
// It builds the normal (32-bit), VIP (8-bit) and VVIP (1-bit) yes bitmaps and
// keeps the weighted tally and pass flag up to date one ballot at a time.
// On close, the frozen result is offered downstream with a valid/ready pair.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous, active-low reset
//   open          in   start a session (IDLE only)
//   close         in   end the session (COLLECT only)
//   ballot_valid  in   ballot offered
//   ballot_ready  out  ballot accepted this cycle if valid (COLLECT only)
//   ballot_class  in   0 normal, 1 VIP, 2 VVIP, 3 illegal
//   ballot_id     in   voter index within class
//   ballot_yes    in   1 = yes, 0 = no
//   np            out  normal-voter yes bitmap
//   vip           out  VIP yes bitmap
//   vvip          out  VVIP yes
//   tally         out  weighted yes count
//   pass          out  tally >= PASS_TH
//   voted         out  accepted ballots this session
//   err           out  one-cycle pulse per rejected ballot
//   out_valid     out  result frozen and offered
//   out_ready     in   downstream takes the result
// -----------------------------------------------------------------------------
module ballot_collector #(
   parameter int W_NP    = 1,
   parameter int W_VIP   = 4,
   parameter int W_VVIP  = 16,
   parameter int PASS_TH = 41
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        open,
   input  logic        close,
   input  logic        ballot_valid,
   output logic        ballot_ready,
   input  logic [1:0]  ballot_class,
   input  logic [4:0]  ballot_id,
   input  logic        ballot_yes,
   output logic [31:0] np,
   output logic [7:0]  vip,
   output logic        vvip,
   output logic [6:0]  tally,
   output logic        pass,
   output logic [5:0]  voted,
   output logic        err,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_PRESENT = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_ballot_ready;
   logic [40:0] r_seen;      // [31:0] normal, [39:32] VIP, [40] VVIP
   logic [31:0] r_np;
   logic [7:0]  r_vip;
   logic        r_vvip;
   logic [6:0]  r_tally;
   logic        r_pass;
   logic [5:0]  r_voted;
   logic        r_err;
   logic        r_out_valid;

   logic        w_legal;
   logic [5:0]  w_idx;
   logic [6:0]  w_weight;
   logic        w_hs;
   logic        w_dup;
   logic        w_accept;
   logic        w_reject;
   logic [6:0]  w_tally_nxt;

   // Ballot decode: legality, position in the seen-bitmap and class weight.
   always_comb begin
      w_legal  = 1'b0;
      w_idx    = 6'd0;
      w_weight = 7'd0;
      case (ballot_class)
         2'd0: begin
            w_legal  = 1'b1;
            w_idx    = {1'b0, ballot_id};
            w_weight = 7'(W_NP);
         end
         2'd1: begin
            w_legal  = (ballot_id < 5'd8);
            w_idx    = 6'd32 + {3'd0, ballot_id[2:0]};
            w_weight = 7'(W_VIP);
         end
         2'd2: begin
            w_legal  = (ballot_id == 5'd0);
            w_idx    = 6'd40;
            w_weight = 7'(W_VVIP);
         end
         default: begin
            w_legal  = 1'b0;
         end
      endcase
   end

   // ballot_ready is high exactly in COLLECT, so the handshake implies COLLECT.
   // Illegal ballots may alias a valid seen position, but they are rejected on
   // legality first, so the aliasing does no harm.
   assign w_hs        = ballot_valid & r_ballot_ready;
   assign w_dup       = r_seen[w_idx];
   assign w_accept    = w_hs & w_legal & ~w_dup;
   assign w_reject    = w_hs & ~(w_legal & ~w_dup);
   assign w_tally_nxt = r_tally + (ballot_yes ? w_weight : 7'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_ballot_ready <= 1'b0;
         r_seen         <= '0;
         r_np           <= '0;
         r_vip          <= '0;
         r_vvip         <= 1'b0;
         r_tally        <= '0;
         r_pass         <= 1'b0;
         r_voted        <= '0;
         r_err          <= 1'b0;
         r_out_valid    <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // open wins over a simultaneous close, which is ignored here.
               if (open) begin
                  r_seen         <= '0;
                  r_np           <= '0;
                  r_vip          <= '0;
                  r_vvip         <= 1'b0;
                  r_tally        <= '0;
                  r_pass         <= 1'b0;
                  r_voted        <= '0;
                  r_ballot_ready <= 1'b1;
                  r_state        <= S_COLLECT;
               end
            end

            S_COLLECT: begin
               // A ballot handshaked together with close is still counted.
               if (w_accept) begin
                  r_seen[w_idx] <= 1'b1;
                  r_voted       <= r_voted + 6'd1;
                  if (ballot_yes) begin
                     r_tally <= w_tally_nxt;
                     r_pass  <= (w_tally_nxt >= 7'(PASS_TH));
                     case (ballot_class)
                        2'd0:    r_np[ballot_id]       <= 1'b1;
                        2'd1:    r_vip[ballot_id[2:0]] <= 1'b1;
                        default: r_vvip                <= 1'b1;
                     endcase
                  end
               end
               if (w_reject) begin
                  r_err <= 1'b1;
               end
               if (close) begin
                  r_ballot_ready <= 1'b0;
                  r_out_valid    <= 1'b1;
                  r_state        <= S_PRESENT;
               end
            end

            S_PRESENT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_ballot_ready <= 1'b0;
               r_out_valid    <= 1'b0;
               r_state        <= S_IDLE;
            end
         endcase
      end
   end

   assign ballot_ready = r_ballot_ready;
   assign np           = r_np;
   assign vip          = r_vip;
   assign vvip         = r_vvip;
   assign tally        = r_tally;
   assign pass         = r_pass;
   assign voted        = r_voted;
   assign err          = r_err;
   assign out_valid    = r_out_valid;

endmodule

// File: doc/ballot_collector.md
# ballot_collector

Sequential front end for the combinational vote evaluator: collects individual ballots one per handshake, rejects malformed or duplicate ones, and assembles the 32-bit normal, 8-bit VIP and 1-bit VVIP ballot vectors the evaluator consumes. The weighted tally and the pass flag are maintained incrementally. On close, it presents the frozen result with a valid/ready handshake to the evaluator or to the checker downstream.

## Interface
- W_NP, 1, weight of a normal voter's yes
- W_VIP, 4, weight of a VIP yes
- W_VVIP, 16, weight of the VVIP yes
- PASS_TH, 41, tally at or above which `pass` = 1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- open  in  1  starts a session; honoured only in IDLE
- close  in  1  ends the session; honoured only in COLLECT
- ballot_valid  in  1  ballot offered
- ballot_ready  out  1  collector accepts a ballot; 1 only in COLLECT
- ballot_class  in  2  0 = normal, 1 = VIP, 2 = VVIP, 3 = illegal
- ballot_id  in  5  voter index within the class
- ballot_yes  in  1  1 = yes, 0 = no
- np  out  32  yes bitmap, normal voters (bit i = voter i)
- vip  out  8  yes bitmap, VIP voters
- vvip  out  1  VVIP yes
- tally  out  7  weighted yes count (max 80)
- pass  out  1  tally >= PASS_TH
- voted  out  6  accepted ballots this session (0..41)
- err  out  1  one-cycle pulse per rejected ballot
- out_valid  out  1  result frozen and offered
- out_ready  in  1  downstream takes the result

## Operation
- States: IDLE, COLLECT, PRESENT.
- IDLE: ballot_ready = 0; out_valid = 0. When open = 1, clear np, vip, vvip, tally, voted and the 41-bit seen-bitmap, then go to COLLECT.
- COLLECT: ballot_ready = 1. A handshake (valid & ready) takes one of two outcomes:
  - Accepted: the ballot is legal and the voter is not yet in the seen-bitmap. Set the seen bit and increment voted. If ballot_yes = 1, set the bitmap bit and add the class weight to tally.
  - Rejected: class 3, VIP id > 7, VVIP id != 0, or a duplicate voter. The ballot is consumed and err pulses. Neither state nor counters change.
- A no-vote still marks the voter as seen. A later yes from the same voter is a duplicate and is rejected.
- close in COLLECT goes to PRESENT. A ballot handshaked in the same cycle as close is processed and included in the result.
- PRESENT: out_valid = 1. np, vip, vvip, tally, pass and voted are held stable. When out_ready = 1, go to IDLE. Outputs keep their values in IDLE until the next open.
- open outside IDLE and close outside COLLECT are ignored. If open and close are both high in IDLE, open takes effect and close is ignored.
- Arithmetic: tally is unsigned 7-bit and cannot overflow with the default weights (32 + 32 + 16 = 80). pass is a registered compare, updated in the same cycle as tally.

## Timing
- Reset values: state = IDLE, all outputs 0, ballot_ready = 0, seen-bitmap cleared.
- open sampled high in IDLE: ballot_ready = 1 from the next cycle.
- Accepted ballot at edge N: np/vip/vvip, tally, pass and voted reflect it after edge N.
- Rejected ballot at edge N: err = 1 for exactly the cycle following edge N.
- close sampled at edge N: out_valid = 1 and ballot_ready = 0 after edge N.
- out_valid & out_ready at edge M: out_valid = 0 after edge M. The minimum session is 3 cycles (open, close, present with out_ready held high).
- Back-to-back ballots: one per cycle. ballot_ready never deasserts inside COLLECT.
- Reset asserted mid-session: immediate return to IDLE with all state cleared. No partial result is presented.

## Test plan
- Reset then open; accept normal ids 0–31 all yes, VIP 0–7 all yes, VVIP yes; close -> np = FFFF_FFFF, vip = FF, vvip = 1, tally = 80, pass = 1, voted = 41.
- Session with normal ids 0–4 yes and VIP 2 yes -> np = 0000_001F, vip = 04, tally = 9, pass = 0, voted = 6.
- Normal id 3 no, then normal id 3 yes -> second ballot raises err for 1 cycle; np bit 3 = 0, voted = 1, tally = 0.
- Illegal ballots (class 3; VIP id 9; VVIP id 1) -> err pulse for each; no counter changes; ballot_ready stays 1.
- VVIP yes handshaked in the same cycle as close -> included: vvip = 1, tally = 16, out_valid the next cycle. Hold out_ready = 0 for 5 cycles -> outputs stable, ballot_valid ignored.
- rst_n low for 1 cycle mid-COLLECT after 10 ballots -> all outputs 0, state IDLE, ballot_ready = 0. A new open starts with voted = 0.
